// File: rtl/io_pkg.sv
// Shared I/O definitions for the processor's output path.
// WORD_W is the datapath word width used by the core and the output port.
package io_pkg;
    localparam int WORD_W = 32;
    localparam int DROP_W = 8;

    typedef logic signed [WORD_W-1:0] word_t;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous register-array FIFO: storage, wrapping pointers, occupancy count.
// The caller guarantees push is only asserted when not full or when popping.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic signed [WIDTH-1:0] wr_data,
    output logic signed [WIDTH-1:0] rd_data,
    output logic [CW-1:0]           count,
    output logic                    full,
    output logic                    empty
);
    logic signed [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never cleared; stale entries are hidden by the count.
    always_ff @(posedge clk) begin
        if (push && !reset) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
endmodule

// File: rtl/output_port_fifo.sv
// Buffered output port: queues results from the Output stage and hands them to a
// valid/ready consumer; overflow is counted rather than back-pressured.
module output_port_fifo
    import io_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int WIDTH  = WORD_W,
    parameter int DROP_W = io_pkg::DROP_W,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic signed [WIDTH-1:0] wr_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_data,
    output logic [CW-1:0]           count,
    output logic                    full,
    output logic                    overflow,
    output logic [DROP_W-1:0]       drop_count,
    output logic signed [WIDTH-1:0] last_value
);
    logic                    push, pop, drop, empty;
    logic signed [WIDTH-1:0] head;
    logic                    overflow_q, overflow_d;
    logic [DROP_W-1:0]       drop_cnt_q, drop_cnt_d;
    logic signed [WIDTH-1:0] last_q, last_d;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_W'(1);
    endfunction

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a write.
    assign pop  = out_valid && out_ready;
    assign push = wr_en && (!full || pop);
    assign drop = wr_en && full && !pop;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_data),
        .rd_data (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        last_d     = last_q;
        if (drop) begin
            overflow_d = 1'b1;
            drop_cnt_d = sat_inc(drop_cnt_q);
        end
        if (push) last_d = wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            last_q     <= '0;
        end else begin
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            last_q     <= last_d;
        end
    end

    assign out_valid  = !empty;
    assign out_data   = out_valid ? head : '0;
    assign overflow   = overflow_q;
    assign drop_count = drop_cnt_q;
    assign last_value = last_q;
endmodule

// File: tb/tb_output_port_fifo.sv
// Directed bench for output_port_fifo with hand-computed expectations.
module tb_output_port_fifo;
    logic               clk = 1'b0;
    logic               reset;
    logic               wr_en;
    logic signed [31:0] wr_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] out_data;
    logic [2:0]         count;
    logic               full;
    logic               overflow;
    logic [7:0]         drop_count;
    logic signed [31:0] last_value;

    int n_checks = 0;
    int n_fail   = 0;

    output_port_fifo dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .count      (count),
        .full       (full),
        .overflow   (overflow),
        .drop_count (drop_count),
        .last_value (last_value)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".out_valid"},  32'(out_valid),  32'd0);
        chk({tag, ".out_data"},   out_data,        32'd0);
        chk({tag, ".count"},      32'(count),      32'd0);
        chk({tag, ".full"},       32'(full),       32'd0);
        chk({tag, ".overflow"},   32'(overflow),   32'd0);
        chk({tag, ".drop_count"}, 32'(drop_count), 32'd0);
        chk({tag, ".last_value"}, last_value,      32'd0);
    endtask

    task automatic push_one(input logic [31:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    logic [31:0] stream_pat [3];

    initial begin
        stream_pat[0] = 32'h8000_0000;
        stream_pat[1] = 32'h7FFF_FFFF;
        stream_pat[2] = 32'h0000_0000;

        reset = 1'b1; wr_en = 1'b0; wr_data = '0; out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        check_reset_state("idle");

        // Single negative value held until the consumer is ready
        push_one(32'hFFFF_FFFB);
        chk("neg.valid", 32'(out_valid), 32'd1);
        chk("neg.data",  out_data, 32'hFFFF_FFFB);
        chk("neg.count", 32'(count), 32'd1);
        chk("neg.last",  last_value, 32'hFFFF_FFFB);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("neg.hold_data",  out_data, 32'hFFFF_FFFB);
            chk("neg.hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("neg.drained_count", 32'(count), 32'd0);
        chk("neg.drained_valid", 32'(out_valid), 32'd0);
        chk("neg.drained_data",  out_data, 32'd0);

        // No fall-through: ready with a write into an empty FIFO pops nothing
        out_ready = 1'b1;
        push_one(32'd77);
        out_ready = 1'b0;
        chk("nofall.count", 32'(count), 32'd1);
        chk("nofall.data",  out_data, 32'd77);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("nofall.empty", 32'(count), 32'd0);

        // Fill, then overflow
        for (int v = 1; v <= 4; v++) push_one(32'(v));
        chk("fill.full",  32'(full), 32'd1);
        chk("fill.count", 32'(count), 32'd4);
        chk("fill.ovf",   32'(overflow), 32'd0);
        push_one(32'd5);
        chk("drop.full",  32'(full), 32'd1);
        chk("drop.count", 32'(count), 32'd4);
        chk("drop.ovf",   32'(overflow), 32'd1);
        chk("drop.cnt",   32'(drop_count), 32'd1);
        chk("drop.last",  last_value, 32'd4);
        out_ready = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            chk("drain1.data", out_data, 32'(v));
            step();
        end
        out_ready = 1'b0;
        chk("drain1.count", 32'(count), 32'd0);

        // Simultaneous push and pop while full
        for (int v = 1; v <= 4; v++) push_one(32'(v));
        out_ready = 1'b1;
        push_one(32'd9);
        out_ready = 1'b0;
        chk("pp.count", 32'(count), 32'd4);
        chk("pp.cnt",   32'(drop_count), 32'd1);
        chk("pp.last",  last_value, 32'd9);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain2.data", out_data, (i == 3) ? 32'd9 : 32'(i + 2));
            step();
        end
        out_ready = 1'b0;
        chk("drain2.count", 32'(count), 32'd0);

        // Saturating drop counter, then reset mid-stream with inputs active
        for (int v = 10; v <= 13; v++) push_one(32'(v));
        wr_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            wr_data = 32'(100 + i);
            step();
            if (i == 252) chk("sat.cnt_254", 32'(drop_count), 32'd254);
        end
        chk("sat.cnt",  32'(drop_count), 32'd255);
        chk("sat.ovf",  32'(overflow), 32'd1);
        chk("sat.last", last_value, 32'd13);
        chk("sat.head", out_data, 32'd10);
        reset = 1'b1;
        out_ready = 1'b1;
        step();
        reset = 1'b0;
        wr_en = 1'b0;
        out_ready = 1'b0;
        check_reset_state("midrst");

        // Streaming at full throughput across pointer wrap
        out_ready = 1'b1;
        wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_data = stream_pat[i % 3];
            step();
            chk("stream.data",  out_data, stream_pat[i % 3]);
            chk("stream.count", 32'(count), 32'd1);
        end
        wr_en = 1'b0;
        step();
        out_ready = 1'b0;
        chk("stream.end_count", 32'(count), 32'd0);
        chk("stream.last", last_value, stream_pat[7 % 3]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
